magnetron_cook_ctrl: RTL

Parametrised next-generation microwave magnetron controller. It adds an internal cook-time down-counter, a power-level duty cycle, pause/resume and a done indication to the start/stop/clear/door interlock of the earlier magnetron control. It sits between the front-panel buttons and door switch and the magnetron drive, and exposes remaining time for the display block.

---
 rtl/magnetron_cook_ctrl_if.sv | 26 ++
 rtl/magnetron_cook_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/magnetron_cook_ctrl_if.sv
// magnetron_cook_ctrl_if: front-panel, door and magnetron-drive signal bundle
interface magnetron_cook_ctrl_if #(
  parameter int TIME_W = 12,
  parameter int PWR_W  = 4
);
  logic              startn;
  logic              stopn;
  logic              clearn;
  logic              door_closed;
  logic              load;
  logic [TIME_W-1:0] set_time;
  logic [PWR_W-1:0]  set_power;
  logic              mag_on;
  logic              cooking;
  logic              paused;
  logic              done;
  logic [TIME_W-1:0] time_left;
  modport master (
    output startn, stopn, clearn, door_closed, load, set_time, set_power,
    input  mag_on, cooking, paused, done, time_left
  );
  modport slave (
    input  startn, stopn, clearn, door_closed, load, set_time, set_power,
    output mag_on, cooking, paused, done, time_left
  );
endinterface

// File: rtl/magnetron_cook_ctrl.sv
// magnetron_cook_ctrl: cook timer, power duty cycle and door interlock for a magnetron
module magnetron_cook_ctrl #(
  parameter int TICK_DIV  = 100,
  parameter int TIME_W    = 12,
  parameter int PWR_STEPS = 10,
  parameter int PWR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  magnetron_cook_ctrl_if.slave  bus
);
  localparam int PRE_W = $clog2(TICK_DIV);
  // one-hot so each status output is a state flop bit
  typedef enum logic [2:0] {IDLE = 3'b000, COOKING = 3'b001, PAUSED = 3'b010, DONE = 3'b100} state_t;
  state_t            r_state;
  logic [2:0]        r_btn_now;
  logic [2:0]        r_btn_prev;
  logic [TIME_W-1:0] r_time;
  logic [PWR_W-1:0]  r_pwr;
  logic [PRE_W-1:0]  r_pre;
  logic [PWR_W-1:0]  r_win;
  logic [2:0]        w_edge;
  logic              w_start;
  logic              w_stop;
  logic              w_clear;
  logic              w_tick;
  logic [PWR_W-1:0]  w_clamp;
  assign w_edge  = r_btn_prev & ~r_btn_now;
  assign w_start = w_edge[0];
  assign w_stop  = w_edge[1];
  assign w_clear = w_edge[2];
  assign w_tick  = r_pre == PRE_W'(TICK_DIV - 1);
  assign w_clamp = (bus.set_power == '0) ? PWR_W'(1) :
                   (bus.set_power > PWR_W'(PWR_STEPS)) ? PWR_W'(PWR_STEPS) : bus.set_power;
  // button sampling; bit 0 start, bit 1 stop, bit 2 clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_btn_now  <= 3'b111;
      r_btn_prev <= 3'b111;
    end else begin
      r_btn_now  <= {bus.clearn, bus.stopn, bus.startn};
      r_btn_prev <= r_btn_now;
    end
  // cook state machine with time, power, prescaler and duty window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_time  <= '0;
      r_pwr   <= PWR_W'(PWR_STEPS);
      r_pre   <= '0;
      r_win   <= '0;
    end else if (w_clear) begin
      r_state <= IDLE;
      r_time  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_time <= bus.set_time;
            r_pwr  <= w_clamp;
          end
          if (w_start && bus.door_closed && r_time != '0) begin
            r_state <= COOKING;
            r_pre   <= '0;
            r_win   <= '0;
          end
        end
        COOKING: begin
          if (!bus.door_closed || w_stop)
            r_state <= PAUSED;
          else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
              r_win  <= (r_win == PWR_W'(PWR_STEPS - 1)) ? '0 : r_win + 1'b1;
              r_time <= r_time - 1'b1;
              if (r_time == TIME_W'(1))
                r_state <= DONE;
            end
          end
        end
        PAUSED: begin
          if (w_stop) begin
            r_state <= IDLE;
            r_time  <= '0;
          end else if (w_start && bus.door_closed) begin
            r_state <= COOKING;
            r_pre   <= '0;
            r_win   <= '0;
          end
        end
        DONE: begin
          if (bus.load) begin
            r_time <= bus.set_time;
            r_pwr  <= w_clamp;
          end
          if (bus.load || w_start || w_stop || !bus.door_closed)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.cooking   = r_state[0];
  assign bus.paused    = r_state[1];
  assign bus.done      = r_state[2];
  assign bus.time_left = r_time;
  assign bus.mag_on    = r_state[0] & bus.door_closed & (r_win < r_pwr);
endmodule
